dc6xx_usq_nxt: RTL and testbench



---
 rtl/usq_pkg.sv | 18 +
 rtl/dc6xx_usq_nxt_if.sv | 53 +++++
 rtl/dc6xx_usq_stk.sv | 58 +++++
 rtl/dc6xx_usq_nxt.sv | 86 ++++++++
 tb/tb_dc6xx_usq_nxt.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/usq_pkg.sv
// Shared definitions for the dc6xx microsequencer next-address stage.
// Branch opcodes and default address parameters.
package usq_pkg;

  localparam int USQ_UADDR_W = 14;
  localparam int USQ_STK_DEPTH = 8;

  localparam logic [13:0] USQ_RESET_VEC = 14'h0000;
  localparam logic [13:0] USQ_TRAP_VEC = 14'h0040;

  localparam logic [2:0] BOP_JMP = 3'd0;
  localparam logic [2:0] BOP_CCBR = 3'd1;
  localparam logic [2:0] BOP_CALL = 3'd2;
  localparam logic [2:0] BOP_RET = 3'd3;
  localparam logic [2:0] BOP_CALLB = 3'd4;
  localparam logic [2:0] BOP_SEQ = 3'd5;

endpackage

// File: rtl/dc6xx_usq_nxt_if.sv
// Microword / condition-code bundle into the next-address stage.
// USQ_STACK_CHECK_EN adds the sticky stack error flag stk_err_h.
interface dc6xx_usq_nxt_if #(
  parameter int UADDR_W = 14,
  parameter int STK_DEPTH = 8
);

  localparam int DW = $clog2(STK_DEPTH) + 1;

  logic d_clk_en_h;
  logic [UADDR_W-1:0] ucode_nxt_h;
  logic [2:0] ucode_bop_h;
  logic [1:0] ccbr_h;
  logic arith_trap_l;
  logic [UADDR_W-1:0] upc_h;
  logic trap_taken_h;
  logic trap_busy_h;
  logic [DW-1:0] stk_depth_h;
`ifdef USQ_STACK_CHECK_EN
  logic stk_err_h;
`endif

  modport master (
`ifdef USQ_STACK_CHECK_EN
    input stk_err_h,
`endif
    output d_clk_en_h,
    output ucode_nxt_h,
    output ucode_bop_h,
    output ccbr_h,
    output arith_trap_l,
    input upc_h,
    input trap_taken_h,
    input trap_busy_h,
    input stk_depth_h
  );

  modport slave (
`ifdef USQ_STACK_CHECK_EN
    output stk_err_h,
`endif
    input d_clk_en_h,
    input ucode_nxt_h,
    input ucode_bop_h,
    input ccbr_h,
    input arith_trap_l,
    output upc_h,
    output trap_taken_h,
    output trap_busy_h,
    output stk_depth_h
  );

endinterface

// File: rtl/dc6xx_usq_stk.sv
// Circular micro-subroutine LIFO; a push when full overwrites the oldest.
// USQ_STACK_CHECK_EN adds a sticky overflow/underflow flag.
module dc6xx_usq_stk #(
  parameter int W = 14,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic pop,
  input logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic empty,
  output logic full,
`ifdef USQ_STACK_CHECK_EN
  output logic err,
`endif
  output logic [$clog2(DEPTH):0] depth
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;

  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] sp;
  logic [DW-1:0] cnt;

  assign rdata = mem[sp - PW'(1)];
  assign empty = (cnt == '0);
  assign full = (cnt == DW'(DEPTH));
  assign depth = cnt;

  // RAM is not reset; writes are blocked while reset is held
  always_ff @(posedge clk) begin
    if (push && rst_n) mem[sp] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
      cnt <= '0;
    end else if (push) begin
      sp <= sp + PW'(1);
      if (!full) cnt <= cnt + DW'(1);
    end else if (pop && !empty) begin
      sp <= sp - PW'(1);
      cnt <= cnt - DW'(1);
    end
  end

`ifdef USQ_STACK_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if ((push && full) || (pop && empty)) err <= 1'b1;
  end
`endif

endmodule

// File: rtl/dc6xx_usq_nxt.sv
// Microsequencer next-address stage: upc mux, trap control, call stack.
// USQ_STACK_CHECK_EN enables stk_err_h on the interface.
module dc6xx_usq_nxt
  import usq_pkg::*;
#(
  parameter int UADDR_W = USQ_UADDR_W,
  parameter int STK_DEPTH = USQ_STK_DEPTH,
  parameter logic [UADDR_W-1:0] RESET_VEC = UADDR_W'(USQ_RESET_VEC),
  parameter logic [UADDR_W-1:0] TRAP_VEC = UADDR_W'(USQ_TRAP_VEC)
) (
  input logic b_clk_l,
  input logic reset_l,
  dc6xx_usq_nxt_if.slave bus
);

  logic [UADDR_W-1:0] upc, upc_inc, upc_d;
  logic [UADDR_W-1:0] nxt, mrg, op_addr;
  logic [UADDR_W-1:0] push_data, stk_rdata;
  logic [2:0] bop;
  logic busy, busy_d;
  logic en, is_call, is_ret, accept;
  logic push, pop, stk_empty, stk_full;

  assign en = bus.d_clk_en_h;
  assign bop = bus.ucode_bop_h;
  assign nxt = bus.ucode_nxt_h;
  assign mrg = {nxt[UADDR_W-1:2], bus.ccbr_h};
  assign upc_inc = upc + UADDR_W'(1);

  always_comb begin
    is_call = (bop == BOP_CALL) || (bop == BOP_CALLB);
    is_ret = (bop == BOP_RET);
    op_addr = upc_inc;
    unique case (1'b1)
      (bop == BOP_JMP),
      (bop == BOP_CALL): op_addr = nxt;
      (bop == BOP_CCBR),
      (bop == BOP_CALLB): op_addr = mrg;
      (bop == BOP_RET): op_addr = stk_empty ? nxt : stk_rdata;
      default: op_addr = upc_inc;
    endcase
  end

  // trap request is a level; refused on call/ret, re-evaluated next cycle
  always_comb begin
    accept = en && !bus.arith_trap_l && !busy && !is_call && !is_ret;
    push = en && (is_call || accept);
    pop = en && is_ret;
    push_data = accept ? op_addr : upc_inc;
    upc_d = accept ? TRAP_VEC : op_addr;
    busy_d = accept || (busy && !is_ret);
  end

  always_ff @(posedge b_clk_l or negedge reset_l) begin
    if (!reset_l) begin
      upc <= RESET_VEC;
      busy <= 1'b0;
    end else if (en) begin
      upc <= upc_d;
      busy <= busy_d;
    end
  end

  dc6xx_usq_stk #(
    .W(UADDR_W),
    .DEPTH(STK_DEPTH)
  ) u_stk (
    .clk(b_clk_l),
    .rst_n(reset_l),
    .push(push),
    .pop(pop),
    .wdata(push_data),
    .rdata(stk_rdata),
    .empty(stk_empty),
    .full(stk_full),
`ifdef USQ_STACK_CHECK_EN
    .err(bus.stk_err_h),
`endif
    .depth(bus.stk_depth_h)
  );

  assign bus.upc_h = upc;
  assign bus.trap_busy_h = busy;
  assign bus.trap_taken_h = accept && reset_l;

endmodule

// File: tb/tb_dc6xx_usq_nxt.sv
// Bench for dc6xx_usq_nxt: directed plan then random ops vs a queue model.
// Define USQ_STACK_CHECK_EN to also check stk_err_h.
module tb_dc6xx_usq_nxt;

  logic b_clk_l;
  logic reset_l;

  dc6xx_usq_nxt_if #(.UADDR_W(14), .STK_DEPTH(8)) bus ();

  dc6xx_usq_nxt dut (
    .b_clk_l(b_clk_l),
    .reset_l(reset_l),
    .bus(bus)
  );

  initial b_clk_l = 1'b0;
  always #5 b_clk_l = ~b_clk_l;

  int n_cmp = 0;
  int n_bad = 0;

  logic [13:0] m_q[$];
  logic [13:0] m_upc;
  logic m_busy;
  logic m_err;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_upc = 14'h0000;
    m_busy = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic m_push(input logic [13:0] a);
    if (m_q.size() == 8) begin
      void'(m_q.pop_front());
      m_err = 1'b1;
    end
    m_q.push_back(a);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_upc"}, 32'(bus.upc_h), 32'(m_upc));
    chk({tag, "_busy"}, 32'(bus.trap_busy_h), 32'(m_busy));
    chk({tag, "_depth"}, 32'(bus.stk_depth_h), 32'(m_q.size()));
`ifdef USQ_STACK_CHECK_EN
    chk({tag, "_err"}, 32'(bus.stk_err_h), 32'(m_err));
`endif
  endtask

  // called at a negedge; returns at the following negedge
  task automatic step(input logic en, input logic [2:0] bop,
                      input logic [13:0] nxt, input logic [1:0] cc,
                      input logic trp, input string tag);
    logic acc;
    logic [13:0] oa;
    bus.d_clk_en_h = en;
    bus.ucode_bop_h = bop;
    bus.ucode_nxt_h = nxt;
    bus.ccbr_h = cc;
    bus.arith_trap_l = trp;
    case (bop)
      3'd0, 3'd2: oa = nxt;
      3'd1, 3'd4: oa = {nxt[13:2], cc};
      3'd3: oa = (m_q.size() != 0) ? m_q[$] : nxt;
      default: oa = m_upc + 14'd1;
    endcase
    acc = en && !trp && !m_busy && !(bop inside {3'd2, 3'd3, 3'd4});
    #1;
    chk({tag, "_taken"}, 32'(bus.trap_taken_h), 32'(acc));
    @(posedge b_clk_l);
    if (en) begin
      if (acc) begin
        m_push(oa);
        m_upc = 14'h0040;
        m_busy = 1'b1;
      end else begin
        if (bop == 3'd2 || bop == 3'd4) m_push(m_upc + 14'd1);
        if (bop == 3'd3) begin
          if (m_q.size() != 0) void'(m_q.pop_back());
          else m_err = 1'b1;
          m_busy = 1'b0;
        end
        m_upc = oa;
      end
    end
    @(negedge b_clk_l);
    chk_state(tag);
  endtask

  initial begin
    m_reset();
    reset_l = 1'b0;
    bus.d_clk_en_h = 1'b0;
    bus.ucode_bop_h = 3'd5;
    bus.ucode_nxt_h = '0;
    bus.ccbr_h = '0;
    bus.arith_trap_l = 1'b1;
    #12;
    chk_state("rst");
    chk("rst_taken", 32'(bus.trap_taken_h), 32'd0);
    @(negedge b_clk_l);
    reset_l = 1'b1;

    for (int i = 0; i < 3; i++) step(1, 3'd5, 14'h0, 2'd0, 1, "seq");
    chk("tp_seq3", 32'(bus.upc_h), 32'h0003);

    step(1, 3'd0, 14'h1234, 2'd0, 1, "jmp");
    chk("tp_jmp", 32'(bus.upc_h), 32'h1234);
    step(1, 3'd1, 14'h0100, 2'b10, 1, "ccbr");
    chk("tp_ccbr", 32'(bus.upc_h), 32'h0102);

    step(1, 3'd0, 14'h0010, 2'd0, 1, "jmp10");
    step(1, 3'd2, 14'h0200, 2'd0, 1, "call");
    chk("tp_call_d", 32'(bus.stk_depth_h), 32'd1);
    step(1, 3'd5, 14'h0, 2'd0, 1, "seq2");
    step(1, 3'd3, 14'h0, 2'd0, 1, "ret");
    chk("tp_ret", 32'(bus.upc_h), 32'h0011);

    step(1, 3'd0, 14'h0300, 2'd0, 0, "trap");
    chk("tp_trap", 32'(bus.upc_h), 32'h0040);
    step(1, 3'd5, 14'h0, 2'd0, 0, "tseq1");
    step(1, 3'd5, 14'h0, 2'd0, 0, "tseq2");
    step(1, 3'd3, 14'h0, 2'd0, 0, "tret");
    chk("tp_tret", 32'(bus.upc_h), 32'h0300);

    for (int i = 0; i < 9; i++)
      step(1, 3'd2, 14'h0100 + 14'(i * 16), 2'd0, 1, "call9");
    chk("tp_full", 32'(bus.stk_depth_h), 32'd8);
    for (int i = 0; i < 8; i++) step(1, 3'd3, 14'h0, 2'd0, 1, "ret8");
    step(1, 3'd3, 14'h3abc, 2'd0, 1, "ret9");
    chk("tp_ret9", 32'(bus.upc_h), 32'h3abc);

    step(0, 3'd2, 14'h0555, 2'd0, 0, "hold1");
    step(0, 3'd2, 14'h0555, 2'd0, 0, "hold2");
    chk("tp_hold", 32'(bus.upc_h), 32'h3abc);

    step(1, 3'd2, 14'h0777, 2'd0, 1, "precall");
    #3;
    reset_l = 1'b0;
    #1;
    m_reset();
    chk_state("mid_rst");
    chk("mid_rst_taken", 32'(bus.trap_taken_h), 32'd0);
    @(negedge b_clk_l);
    reset_l = 1'b1;

    for (int i = 0; i < 400; i++) begin
      logic en;
      logic trp;
      en = ($urandom_range(0, 9) != 0);
      trp = ($urandom_range(0, 3) != 0);
      step(en, 3'($urandom_range(0, 7)), 14'($urandom),
           2'($urandom), trp, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
